pipe_cla_adder: RTL and testbench

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

---
 rtl/pipe_arith_pkg.sv | 13 +
 rtl/cla4_group.sv | 34 +++
 rtl/pipe_cla_adder.sv | 147 ++++++++++++++
 tb/tb_pipe_cla_adder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_arith_pkg.sv
// Shared arithmetic constants for the pipelined adders.
// Holds default sizing and slice-width derivation.
package pipe_arith_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int STAGES_DEF = 2;
  localparam int GRP        = 4;

  function automatic int slice_w(input int w, input int s);
    return w / s;
  endfunction

endpackage

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead group: local sum plus group G/P.
// Internal carries are flat lookahead from ci.
module cla4_group (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       g,
  output logic       p
);

  logic [3:0] gb;
  logic [3:0] pb;
  logic [3:0] c;

  assign gb = x & y;
  assign pb = x ^ y;

  assign c[0] = ci;
  assign c[1] = gb[0] | (pb[0] & ci);
  assign c[2] = gb[1] | (pb[1] & gb[0])
              | (pb[1] & pb[0] & ci);
  assign c[3] = gb[2] | (pb[2] & gb[1])
              | (pb[2] & pb[1] & gb[0])
              | (pb[2] & pb[1] & pb[0] & ci);

  assign s = pb ^ c;

  assign g = gb[3] | (pb[3] & gb[2])
           | (pb[3] & pb[2] & gb[1])
           | (pb[3] & pb[2] & pb[1] & gb[0]);
  assign p = &pb;

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one slice per stage.
// Valid/ready handshake with full-throughput stall chain.
module pipe_cla_adder
  import pipe_arith_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = slice_w(WIDTH, STAGES);
  localparam int NG = SW / GRP;
  localparam int L  = STAGES - 1;

  logic [WIDTH-1:0] ar [STAGES];
  logic [WIDTH-1:0] br [STAGES];
  logic [WIDTH-1:0] sr [STAGES];
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] cr;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] ld;

  // A stage stalls only if it and every stage above it is full
  // while the sink refuses the head beat.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int k = L; k >= 0; k--) begin
      adv[k] = v[k] & ~(full & ~out_ready);
      full   = full & v[k];
    end
  end

  assign ld       = ~v | adv;
  assign in_ready = rst_n & ld[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] ai, bi, si, ns;
    logic             ci, vi;
    logic [NG-1:0]    gg, gp;
    logic [NG:0]      gc;
    logic [SW-1:0]    ss;
    logic [WIDTH-1:0] aq, bq, sq;
    logic             vq, cq;

    if (k == 0) begin : g_in
      assign ai = a;
      assign bi = sub ? ~b : b;
      assign si = '0;
      assign ci = sub | cin;
      assign vi = in_valid;
    end else begin : g_fwd
      assign ai = ar[k-1];
      assign bi = br[k-1];
      assign si = sr[k-1];
      assign ci = cr[k-1];
      assign vi = v[k-1];
    end

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla4_group u_grp (
        .x  (ai[k*SW + j*GRP +: GRP]),
        .y  (bi[k*SW + j*GRP +: GRP]),
        .ci (gc[j]),
        .s  (ss[j*GRP +: GRP]),
        .g  (gg[j]),
        .p  (gp[j])
      );
    end

    // Second-level lookahead across the slice's groups.
    always_comb begin
      logic acc, pp;
      gc    = '0;
      gc[0] = ci;
      for (int j = 1; j <= NG; j++) begin
        acc = 1'b0;
        pp  = 1'b1;
        for (int i = j - 1; i >= 0; i--) begin
          acc = acc | (pp & gg[i]);
          pp  = pp & gp[i];
        end
        gc[j] = acc | (pp & ci);
      end
    end

    always_comb begin
      ns = si;
      ns[k*SW +: SW] = ss;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vq <= 1'b0;
        cq <= 1'b0;
        aq <= '0;
        bq <= '0;
        sq <= '0;
      end else begin
        if (ld[k]) vq <= vi;
        if (ld[k] && vi) begin
          aq <= ai;
          bq <= bi;
          sq <= ns;
          cq <= gc[NG];
        end
      end
    end

    assign v[k]  = vq;
    assign cr[k] = cq;
    assign ar[k] = aq;
    assign br[k] = bq;
    assign sr[k] = sq;

    if (k == L) begin : g_zero
      logic zq;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zq <= 1'b0;
        else if (ld[k] && vi) zq <= ~|ns;
      end
      assign zero = zq;
    end
  end

  assign out_valid = v[L];
  assign sum       = sr[L];
  assign cout      = cr[L];
  assign ovf       = sr[L][WIDTH-1] ^ ar[L][WIDTH-1]
                   ^ br[L][WIDTH-1] ^ cr[L];

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder and a parameter sweep.
// Random streams are compared to an arithmetic reference model.
module tb_pipe_cla_adder;

  localparam int ND = 4;
  localparam int N  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        sw_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  int checks = 0;
  int errors = 0;

  int wd[ND] = '{32, 8, 16, 64};
  int st[ND] = '{2, 1, 4, 8};

  logic [63:0] osum [ND];
  logic        ovld [ND];
  logic        ocout[ND];
  logic        oovf [ND];
  logic        ozero[ND];
  logic        ordy [ND];

  logic [31:0] s32;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [63:0] s64;

  assign osum[0] = {32'b0, s32};
  assign osum[1] = {56'b0, s8};
  assign osum[2] = {48'b0, s16};
  assign osum[3] = s64;

  always #5 clk = ~clk;

  pipe_cla_adder #(.WIDTH(32), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ordy[0]),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
    .out_valid(ovld[0]), .out_ready(out_ready),
    .sum(s32), .cout(ocout[0]), .ovf(oovf[0]),
    .zero(ozero[0])
  );

  pipe_cla_adder #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(ordy[1]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(ovld[1]), .out_ready(1'b1),
    .sum(s8), .cout(ocout[1]), .ovf(oovf[1]),
    .zero(ozero[1])
  );

  pipe_cla_adder #(.WIDTH(16), .STAGES(4)) u_w16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(ordy[2]),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(ovld[2]), .out_ready(1'b1),
    .sum(s16), .cout(ocout[2]), .ovf(oovf[2]),
    .zero(ozero[2])
  );

  pipe_cla_adder #(.WIDTH(64), .STAGES(8)) u_w64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(ordy[3]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ovld[3]), .out_ready(1'b1),
    .sum(s64), .cout(ocout[3]), .ovf(oovf[3]),
    .zero(ozero[3])
  );

  // Returns {ovf, cout, sum} for a w-bit add/sub.
  function automatic logic [65:0] model(
    input logic [63:0] x, input logic [63:0] y,
    input logic ci, input logic sb, input int w);
    logic [64:0] m, full;
    logic [63:0] xx, yy, s;
    logic co, ov;
    m    = (65'd1 << w) - 65'd1;
    xx   = x & m[63:0];
    yy   = sb ? (~y & m[63:0]) : (y & m[63:0]);
    full = {1'b0, xx} + {1'b0, yy}
         + (sb ? 65'd1 : {64'd0, ci});
    s    = full[63:0] & m[63:0];
    co   = full[w];
    ov   = (xx[w-1] == yy[w-1]) && (s[w-1] != xx[w-1]);
    return {ov, co, s};
  endfunction

  task automatic run_one(input logic [63:0] ax,
                         input logic [63:0] bx,
                         input logic ci, input logic sb,
                         output int lat);
    @(negedge clk);
    a = ax; b = bx; cin = ci; sub = sb;
    in_valid = 1'b1; out_ready = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (ovld[0]) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ovld[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got=%b exp=0", ovld[0]);
    end
    checks++;
    if (ordy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready got=%b exp=0", ordy[0]);
    end
    checks++;
    if ({osum[0], ocout[0], oovf[0], ozero[0]} !== '0) begin
      errors++;
      $display("FAIL rst_outputs sum=%h c=%b o=%b z=%b exp=0",
               osum[0], ocout[0], oovf[0], ozero[0]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (ordy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rel_in_ready got=%b exp=1", ordy[0]);
    end
  endtask

  task automatic test_add();
    int lat;
    run_one(64'h1, 64'hFFFF_FFFF, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL add_latency got=%0d exp=2", lat);
    end
    checks++;
    if ({osum[0], ocout[0], ozero[0], oovf[0]}
        !== {64'h0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_result sum=%h c=%b z=%b o=%b exp 0/1/1/0",
               osum[0], ocout[0], ozero[0], oovf[0]);
    end
  endtask

  task automatic test_sub_ovf();
    int lat;
    run_one(64'h8000_0000, 64'h1, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL sub_latency got=%0d exp=2", lat);
    end
    checks++;
    if ({osum[0], ocout[0], oovf[0], ozero[0]}
        !== {64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_result sum=%h c=%b o=%b z=%b exp 7fffffff/1/1/0",
               osum[0], ocout[0], oovf[0], ozero[0]);
    end
  endtask

  task automatic test_backpressure();
    int sent, got;
    logic iv, ov, stall, drop;
    logic [63:0] s, ps;
    sent = 0; got = 0; stall = 1'b0; drop = 1'b0; ps = '0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 5);
      a = 64'(sent + 1); b = 64'(sent + 1);
      cin = 1'b0; sub = 1'b0;
      #1;
      iv = ordy[0]; ov = ovld[0]; s = osum[0];
      if (!iv) drop = 1'b1;
      if (stall) begin
        checks++;
        if (!ov || s !== ps) begin
          errors++;
          $display("FAIL bp_stable v=%b sum=%h exp v=1 sum=%h",
                   ov, s, ps);
        end
      end
      @(posedge clk);
      if (in_valid && iv) sent++;
      if (ov && out_ready) begin
        checks++;
        if (got >= 5 || s !== 64'(2 * (got + 1))) begin
          errors++;
          $display("FAIL bp_result idx=%0d sum=%h exp=%h",
                   got, s, 2 * (got + 1));
        end
        got++;
      end
      stall = ov && !out_ready;
      ps = s;
    end
    checks++;
    if (got !== 5) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=5", got);
    end
    checks++;
    if (drop !== 1'b1) begin
      errors++;
      $display("FAIL bp_in_ready_drop got=%b exp=1", drop);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    a = 64'd7; b = 64'd7; sub = 1'b0; cin = 1'b0;
    @(negedge clk);
    a = 64'd9; b = 64'd9;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ovld[0] !== 1'b0 || ordy[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst v=%b rdy=%b exp 0/0", ovld[0], ordy[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (ordy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_ready got=%b exp=1", ordy[0]);
    end
    repeat (6) begin
      @(negedge clk);
      if (ovld[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_ghost out_valid seen=%b exp=0", seen);
    end
  endtask

  task automatic test_throughput();
    logic [63:0] ra[N], rb[N];
    logic        rc[N], rs[N];
    logic [65:0] e;
    int idx;
    logic ev;
    for (int t = 0; t < N + 10; t++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (t < N) begin
        ra[t] = {$urandom, $urandom};
        rb[t] = {$urandom, $urandom};
        if (t % 10 == 0) rb[t] = ra[t];
        rc[t] = 1'($urandom);
        rs[t] = 1'($urandom);
        a = ra[t]; b = rb[t]; cin = rc[t]; sub = rs[t];
        in_valid = 1'b1; sw_valid = 1'b1;
      end else begin
        in_valid = 1'b0; sw_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        idx = t - st[d] + 1;
        ev = (idx >= 0 && idx < N);
        checks++;
        if (ovld[d] !== ev) begin
          errors++;
          $display("FAIL tp_valid w=%0d t=%0d got=%b exp=%b",
                   wd[d], t, ovld[d], ev);
        end
        if (ev) begin
          e = model(ra[idx], rb[idx], rc[idx], rs[idx], wd[d]);
          checks++;
          if ({oovf[d], ocout[d], osum[d]} !== e ||
              ozero[d] !== (e[63:0] == 64'd0)) begin
            errors++;
            $display("FAIL tp_data w=%0d i=%0d got=%b/%b/%h/%b exp=%b/%b/%h/%b",
                     wd[d], idx, oovf[d], ocout[d], osum[d], ozero[d],
                     e[65], e[64], e[63:0], e[63:0] == 64'd0);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_ovf();
    test_backpressure();
    test_reset_midflight();
    test_throughput();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
